// File: rtl/oct_noc_pkg.sv
// Shared definitions for the PE-array multicast bus: default widths, dispatcher FSM states
// and the bus-word payload seen by the dispatcher and every PE router.
package oct_noc_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ID_WIDTH   = 8;
  localparam int unsigned CNT_WIDTH  = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } disp_state_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
  } bus_word_t;

endpackage

// File: rtl/mc_id_seq.sv
// Tag sequencer: walks words_per_id words under each of id_count tags, stepping the tag by
// id_stride (mod 2^ID_WIDTH). last flags the final word of the program.
module mc_id_seq #(
  parameter int unsigned ID_WIDTH  = oct_noc_pkg::ID_WIDTH,
  parameter int unsigned CNT_WIDTH = oct_noc_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 adv,
  input  logic [ID_WIDTH-1:0]  id_base,
  input  logic [ID_WIDTH-1:0]  id_stride,
  input  logic [CNT_WIDTH-1:0] id_count,
  input  logic [CNT_WIDTH-1:0] words_per_id,
  output logic [ID_WIDTH-1:0]  cur_id,
  output logic                 last,
  output logic                 zero_len_c
);

  logic [ID_WIDTH-1:0]  cur_id_q, cur_id_d, stride_q, stride_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d, grp_cnt_q, grp_cnt_d;
  logic [CNT_WIDTH-1:0] count_q, count_d, wpi_q, wpi_d;
  logic                 grp_end;

  assign grp_end    = (word_cnt_q == wpi_q - CNT_WIDTH'(1));
  assign last       = grp_end && (grp_cnt_q == count_q - CNT_WIDTH'(1));
  assign zero_len_c = (count_q == '0) || (wpi_q == '0);
  assign cur_id     = cur_id_q;

  always_comb begin
    cur_id_d   = cur_id_q;
    stride_d   = stride_q;
    word_cnt_d = word_cnt_q;
    grp_cnt_d  = grp_cnt_q;
    count_d    = count_q;
    wpi_d      = wpi_q;
    if (clr) begin
      cur_id_d   = '0;
      stride_d   = '0;
      word_cnt_d = '0;
      grp_cnt_d  = '0;
      count_d    = '0;
      wpi_d      = '0;
    end else if (load) begin
      cur_id_d   = id_base;
      stride_d   = id_stride;
      word_cnt_d = '0;
      grp_cnt_d  = '0;
      count_d    = id_count;
      wpi_d      = words_per_id;
    end else if (adv) begin
      // Group boundary: restart the word count and step to the next tag.
      if (grp_end) begin
        word_cnt_d = '0;
        cur_id_d   = cur_id_q + stride_q;
        grp_cnt_d  = grp_cnt_q + CNT_WIDTH'(1);
      end else begin
        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_id_q   <= '0;
      stride_q   <= '0;
      word_cnt_q <= '0;
      grp_cnt_q  <= '0;
      count_q    <= '0;
      wpi_q      <= '0;
    end else begin
      cur_id_q   <= cur_id_d;
      stride_q   <= stride_d;
      word_cnt_q <= word_cnt_d;
      grp_cnt_q  <= grp_cnt_d;
      count_q    <= count_d;
      wpi_q      <= wpi_d;
    end
  end

endmodule

// File: rtl/mc_bus_dispatcher.sv
// Multicast bus dispatcher: pulls global-buffer words and issues them on the shared PE bus
// tagged with a programmed ID sequence. DISPATCH_PERF_CNT_EN adds stall/idle cycle counters.
module mc_bus_dispatcher #(
  parameter int unsigned DATA_WIDTH = oct_noc_pkg::DATA_WIDTH,
  parameter int unsigned ID_WIDTH   = oct_noc_pkg::ID_WIDTH,
  parameter int unsigned CNT_WIDTH  = oct_noc_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ID_WIDTH-1:0]   id_base,
  input  logic [ID_WIDTH-1:0]   id_stride,
  input  logic [CNT_WIDTH-1:0]  id_count,
  input  logic [CNT_WIDTH-1:0]  words_per_id,
  input  logic [DATA_WIDTH-1:0] gb_data,
  input  logic                  gb_valid,
  output logic                  gb_ready,
  input  logic                  bus_stall,
  output logic [ID_WIDTH-1:0]   bus_source_id,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_data_valid,
  output logic                  busy,
  output logic                  done
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           idle_cycles
`endif
);
  import oct_noc_pkg::*;

  disp_state_e           state_q, state_d;
  logic                  load, xfer, last, zero_len_c;
  logic [ID_WIDTH-1:0]   cur_id;
  logic [ID_WIDTH-1:0]   bus_id_q, bus_id_d;
  logic [DATA_WIDTH-1:0] bus_data_q, bus_data_d;
  logic                  bus_valid_q, bus_valid_d;
  logic                  busy_q, busy_d, done_q, done_d;

  mc_id_seq #(.ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_id_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (abort),
    .load         (load),
    .adv          (xfer),
    .id_base      (id_base),
    .id_stride    (id_stride),
    .id_count     (id_count),
    .words_per_id (words_per_id),
    .cur_id       (cur_id),
    .last         (last),
    .zero_len_c   (zero_len_c)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    gb_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        gb_ready = !bus_stall && !zero_len_c;
        if (zero_len_c || (gb_valid && gb_ready && last)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort dominates start and any in-flight transfer.
    if (abort) begin
      state_d  = ST_IDLE;
      load     = 1'b0;
      gb_ready = 1'b0;
    end
    xfer        = gb_valid && gb_ready;
    bus_valid_d = xfer;
    bus_data_d  = xfer ? gb_data : '0;
    bus_id_d    = xfer ? cur_id : bus_id_q;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_id_q    <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_id_q    <= bus_id_d;
      bus_data_q  <= bus_data_d;
      bus_valid_q <= bus_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus_source_id  = bus_id_q;
  assign bus_data       = bus_data_q;
  assign bus_data_valid = bus_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_q, stall_d, idle_q, idle_d;

  // Saturating RUN-state counters, cleared when a program is accepted.
  always_comb begin
    stall_d = stall_q;
    idle_d  = idle_q;
    if (load) begin
      stall_d = '0;
      idle_d  = '0;
    end else if (state_q == ST_RUN) begin
      if (gb_valid && bus_stall && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if (!gb_valid && (idle_q != '1))              idle_d  = idle_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      idle_q  <= '0;
    end else begin
      stall_q <= stall_d;
      idle_q  <= idle_d;
    end
  end

  assign stall_cycles = stall_q;
  assign idle_cycles  = idle_q;
`endif

endmodule

// File: tb/tb_mc_bus_dispatcher.sv
// Directed bench for mc_bus_dispatcher: tag-list reference model checked every cycle, plus
// literal expectations per scenario.
module tb_mc_bus_dispatcher;

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 8;
  localparam int unsigned CW = 12;

  logic          clk;
  logic          rst_n;
  logic          start, abort, gb_valid, bus_stall;
  logic [IW-1:0] id_base, id_stride;
  logic [CW-1:0] id_count, words_per_id;
  logic [DW-1:0] gb_data;
  logic          gb_ready, bus_data_valid, busy, done;
  logic [IW-1:0] bus_source_id;
  logic [DW-1:0] bus_data;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0]   stall_cycles, idle_cycles;
`endif

  mc_bus_dispatcher dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .id_base        (id_base),
    .id_stride      (id_stride),
    .id_count       (id_count),
    .words_per_id   (words_per_id),
    .gb_data        (gb_data),
    .gb_valid       (gb_valid),
    .gb_ready       (gb_ready),
    .bus_stall      (bus_stall),
    .bus_source_id  (bus_source_id),
    .bus_data       (bus_data),
    .bus_data_valid (bus_data_valid),
    .busy           (busy),
    .done           (done)
`ifdef DISPATCH_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .idle_cycles    (idle_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the program is expanded into the full list of tags at start.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t       phase;
  logic [IW-1:0] tags[$];
  int            idx, total;
  logic          exp_valid, exp_done, exp_busy, m_ready;
  logic [DW-1:0] exp_data;
  logic [IW-1:0] exp_id;
  logic [31:0]   m_stall, m_idle;

  logic [IW-1:0] log_id[$];
  logic [DW-1:0] log_data[$];
  int            log_cyc[$];
  int            cyc_n = 0;
  int            done_cnt, done_cyc, done_at, start_cyc, ready_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(bus_data_valid), 32'd0);
      chk("rst_data",  32'(bus_data), 32'd0);
      chk("rst_id",    32'(bus_source_id), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_ready", 32'(gb_ready), 32'd0);
      phase = M_IDLE; idx = 0; total = 0;
      exp_valid = 0; exp_done = 0; exp_busy = 0; exp_data = '0; exp_id = '0;
      m_stall = '0; m_idle = '0;
    end else begin
      chk("bus_valid", 32'(bus_data_valid), 32'(exp_valid));
      chk("bus_data",  32'(bus_data), 32'(exp_data));
      chk("bus_id",    32'(bus_source_id), 32'(exp_id));
      chk("done",      32'(done), 32'(exp_done));
      chk("busy",      32'(busy), 32'(exp_busy));
`ifdef DISPATCH_PERF_CNT_EN
      chk("stall_cycles", stall_cycles, m_stall);
      chk("idle_cycles",  idle_cycles, m_idle);
`endif
      if (bus_data_valid) begin
        log_id.push_back(bus_source_id);
        log_data.push_back(bus_data);
        log_cyc.push_back(cyc_n);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n;
        done_at  = log_id.size();
      end
      m_ready = (phase == M_RUN) && !bus_stall && !abort && (total != 0);
      chk("gb_ready", 32'(gb_ready), 32'(m_ready));
      if (gb_ready) ready_cnt++;
      if (phase == M_RUN) begin
        if (gb_valid && bus_stall && m_stall != '1) m_stall = m_stall + 1;
        if (!gb_valid && m_idle != '1)              m_idle  = m_idle + 1;
      end
      exp_valid = 1'b0;
      exp_data  = '0;
      if (abort) begin
        phase = M_IDLE;
      end else begin
        case (phase)
          M_IDLE: if (start) begin
            tags.delete();
            for (int g = 0; g < int'(id_count); g++)
              for (int w = 0; w < int'(words_per_id); w++)
                tags.push_back(IW'(int'(id_base) + g * int'(id_stride)));
            total     = tags.size();
            idx       = 0;
            phase     = M_RUN;
            start_cyc = cyc_n;
            m_stall   = '0;
            m_idle    = '0;
          end
          M_RUN: begin
            if (total == 0) phase = M_DONE;
            else if (gb_valid && m_ready) begin
              exp_valid = 1'b1;
              exp_data  = gb_data;
              exp_id    = tags[idx];
              idx++;
              if (idx == total) phase = M_DONE;
            end
          end
          default: phase = M_IDLE;
        endcase
      end
      exp_done = (phase == M_DONE);
      exp_busy = (phase != M_IDLE);
    end
    cyc_n++;
  end

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic cyc(input logic st, input logic ab, input logic gv, input logic stl,
                     input logic [DW-1:0] d);
    start = st; abort = ab; gb_valid = gv; bus_stall = stl; gb_data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic feed(input int n, input logic [DW-1:0] d0);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, DW'(d0 + DW'(i)));
  endtask

  task automatic prog(input logic [IW-1:0] b, input logic [IW-1:0] s,
                      input logic [CW-1:0] c, input logic [CW-1:0] w);
    id_base = b; id_stride = s; id_count = c; words_per_id = w;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic clear_logs();
    log_id.delete(); log_data.delete(); log_cyc.delete();
    done_cnt = 0; done_cyc = -1; done_at = -1; ready_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; abort = 0; gb_valid = 0; bus_stall = 0; gb_data = '0;
    id_base = '0; id_stride = '0; id_count = '0; words_per_id = '0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Basic two groups of two
    clear_logs();
    prog(8'd3, 8'd1, 12'd2, 12'd2);
    feed(4, 16'hA000);
    idle(3);
    chk("t1_words", log_id.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_id%0d", i), 32'(log_id[i]), (i < 2) ? 32'd3 : 32'd4);
      chk($sformatf("t1_data%0d", i), 32'(log_data[i]), 32'hA000 + i);
    end
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_with_4th", done_at, 4);

    // Tag wrap
    clear_logs();
    prog(8'hFE, 8'd1, 12'd3, 12'd1);
    feed(3, 16'hB000);
    idle(3);
    chk("t2_words", log_id.size(), 3);
    chk("t2_id0", 32'(log_id[0]), 32'hFE);
    chk("t2_id1", 32'(log_id[1]), 32'hFF);
    chk("t2_id2", 32'(log_id[2]), 32'h00);
    chk("t2_done_cnt", done_cnt, 1);

    // Stall after the first word
    clear_logs();
    prog(8'h20, 8'd5, 12'd1, 12'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'hA000);
    for (int i = 0; i < 3; i++) begin
      gb_valid = 1'b1; bus_stall = 1'b1; gb_data = 16'hDEAD;
      #1 chk("t3_ready_stalled", 32'(gb_ready), 32'd0);
      @(posedge clk); #1;
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'hA001);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'hA002);
    idle(3);
    chk("t3_words", log_id.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_id%0d", i), 32'(log_id[i]), 32'h20);
      chk($sformatf("t3_data%0d", i), 32'(log_data[i]), 32'hA000 + i);
    end
    chk("t3_gap_stall", log_cyc[1] - log_cyc[0], 4);
    chk("t3_gap_resume", log_cyc[2] - log_cyc[1], 1);
    chk("t3_done_cnt", done_cnt, 1);

    // gb_valid bubbles
    clear_logs();
    prog(8'h30, 8'd1, 12'd1, 12'd4);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, (i % 2) == 0, 1'b0, DW'(16'hC000 + i));
    idle(3);
    chk("t4_words", log_id.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_data%0d", i), 32'(log_data[i]), 32'hC000 + 2 * i);
    for (int i = 1; i < 4; i++) chk($sformatf("t4_gap%0d", i), log_cyc[i] - log_cyc[i-1], 2);
    chk("t4_done_cnt", done_cnt, 1);

    // Zero-length program
    clear_logs();
    prog(8'h50, 8'd1, 12'd2, 12'd0);
    idle(4);
    chk("t5_words", log_id.size(), 0);
    chk("t5_ready_cnt", ready_cnt, 0);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_done_latency", done_cyc - start_cyc, 2);

    // start while busy is ignored
    clear_logs();
    prog(8'h40, 8'd1, 12'd1, 12'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'hD000);
    id_base = 8'h99;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'hD001);
    idle(3);
    chk("t5b_words", log_id.size(), 2);
    chk("t5b_id0", 32'(log_id[0]), 32'h40);
    chk("t5b_id1", 32'(log_id[1]), 32'h40);
    chk("t5b_done_cnt", done_cnt, 1);

    // Abort after 2 of 6 words, then replay
    clear_logs();
    prog(8'h10, 8'd2, 12'd2, 12'd3);
    feed(2, 16'hE000);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'hE002);
    chk("t6_busy_after_abort", 32'(busy), 32'd0);
    idle(3);
    chk("t6_words", log_id.size(), 2);
    chk("t6_no_done", done_cnt, 0);
    clear_logs();
    prog(8'h10, 8'd2, 12'd2, 12'd3);
    feed(6, 16'hF000);
    idle(3);
    chk("t6r_words", log_id.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6r_id%0d", i), 32'(log_id[i]), (i < 3) ? 32'h10 : 32'h12);
      chk($sformatf("t6r_data%0d", i), 32'(log_data[i]), 32'hF000 + i);
    end
    chk("t6r_done_cnt", done_cnt, 1);

    // Asynchronous reset while a word is on the bus
    clear_logs();
    prog(8'h60, 8'd1, 12'd1, 12'd4);
    feed(1, 16'h1111);
    chk("t7_valid_before_reset", 32'(bus_data_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_valid_async", 32'(bus_data_valid), 32'd0);
    chk("t7_busy_async", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
